g_logic_pipe: RTL
=================

// Module: g_logic_pipe
// PURPOSE
//  Parametrised, pipelined successor of the fixed 32-bit OR gate in ALU32_GATE.
//  Computes one of 8 bitwise ops on two WIDTH-bit operands and registers the result.
//  Uses a valid/ready handshake with a 2-entry skid buffer, so the ALU datapath can
//  stall without combinational ready paths. Sits between operand fetch and ALU result mux.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (>=1)
// PORTS
//  Clk        in   1      rising-edge clock
//  Rst_n      in   1      asynchronous active-low reset
//  In_valid   in   1      operand beat valid
//  In_ready   out  1      block can accept a beat this cycle
//  Op         in   3      op select, sampled with In1/In2
//  In1        in   WIDTH  operand A
//  In2        in   WIDTH  operand B
//  Out_valid  out  1      result valid
//  Out_ready  in   1      consumer accepts result
//  Out        out  WIDTH  result
//  Out_zero   out  1      result == 0 (flag feature)
//  Out_ones   out  1      result == all ones (flag feature)
// BEHAVIOUR
//  - Ops: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 NAND, 101 XNOR, 110 In1&~In2, 111 pass In1.
//  - Accept when In_valid&&In_ready; deliver when Out_valid&&Out_ready.
//  - Storage: main reg (drives Out) + skid reg; occupancy 0..2. Latency 1 cycle: a beat
//    accepted at edge N is on Out after edge N when main is empty or draining.
//  - In_ready is a register output: 1 when skid empty; never depends on Out_ready combinationally.
//  - Main empty: accepted beat -> main. Main full and draining: accepted beat -> main.
//  - Main full and not draining: accepted beat -> skid, In_ready drops next cycle.
//  - Drain with skid full: skid -> main, In_ready rises next cycle; no beat lost or duplicated.
//  - Order is strict FIFO; Out/flags stay stable while Out_valid&&!Out_ready.
//  - Result computed at accept time from the Op/In1/In2 of that beat; Op changes later are ignored.
//  - In_valid while In_ready=0: ignored, no state change.
//  - Reset (any time, incl. mid-transfer): Out_valid=0, In_ready=1 (after release), Out=0,
//    Out_zero=0, Out_ones=0, both entries emptied; in-flight beats discarded.
//  - During reset In_ready=0.
// CONFIGURATION
//  - Macro G_LOGIC_PIPE_FLAGS_EN.
//  - Defined: Out_zero/Out_ones computed at accept, stored per entry, travel with data.
//  - Undefined: flag storage omitted; Out_zero and Out_ones tied to 0; ports remain.
// STRUCTURE
//  - Package g_logic_pkg: 3-bit op typedef/enum (G_AND..G_PASS), OP_W=3 constant,
//    function g_logic_eval(op, a, b) shared with the combinational ALU gates.
//  - One sub-module, g_skid_reg: 2-entry valid/ready skid buffer, payload width param
//    (WIDTH, or WIDTH+2 with flags). Top does op eval + flag calc + instantiation.
// TESTING
//  - WIDTH=32, Op=001, In1=0xF0F0_0000, In2=0x0F0F_00FF, Out_ready=1 -> next cycle
//    Out=0xFFFF_00FF, Out_valid=1.
//  - All 8 ops with In1=0xA5A5_A5A5, In2=0xFFFF_0000 -> AND 0xA5A5_0000, NOR 0x0000_5A5A,
//    XNOR 0xA5A5_5A5A, ANDN 0x0000_A5A5, PASS 0xA5A5_A5A5.
//  - Out_ready=0, feed 3 beats back-to-back -> 2 accepted, In_ready=0 after 2nd.
//    Raise Out_ready -> beats out in order, In_ready=1 one cycle after first drain.
//  - Random In_valid/Out_ready, 10k beats, scoreboard -> no loss, no dup, order kept.
//    Out stable during every stall.
//  - Assert Rst_n=0 with 2 beats buffered -> Out_valid=0, Out=0 immediately.
//    After release In_ready=1 and no stale beat appears.
//  - Flags EN, XOR of 0x1234_5678 with itself -> Out=0, Out_zero=1.
//    NOR of 0,0 -> Out_ones=1. With macro undefined -> both flags 0 always.

Source files
------------

// File: rtl/g_logic_pkg.sv
// Op encoding and per-bit evaluator shared by the pipelined logic unit and the
// combinational ALU gates.
package g_logic_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      G_AND  = 3'b000,
      G_OR   = 3'b001,
      G_XOR  = 3'b010,
      G_NOR  = 3'b011,
      G_NAND = 3'b100,
      G_XNOR = 3'b101,
      G_ANDN = 3'b110,
      G_PASS = 3'b111
   } g_op_e;

   // Single-bit evaluator; callers replicate it across the operand width.
   function automatic logic g_logic_eval(input g_op_e op, input logic a, input logic b);
      logic r;
      r = 1'b0;
      case (op)
         G_AND:   r = a & b;
         G_OR:    r = a | b;
         G_XOR:   r = a ^ b;
         G_NOR:   r = ~(a | b);
         G_NAND:  r = ~(a & b);
         G_XNOR:  r = ~(a ^ b);
         G_ANDN:  r = a & ~b;
         default: r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/g_skid_reg.sv
// Two-entry valid/ready skid buffer: main register drives the output, skid
// register absorbs one beat while the consumer stalls. Ready is registered.
module g_skid_reg #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_valid,
   output logic         push_ready,
   input  logic [W-1:0] push_data,
   output logic         pop_valid,
   input  logic         pop_ready,
   output logic [W-1:0] pop_data
);

   logic         main_vld, skid_vld, rdy_q;
   logic [W-1:0] main_q, skid_q;
   logic         main_vld_n, skid_vld_n;
   logic [W-1:0] main_n, skid_n;
   logic         accept, drain;

   assign accept = push_valid & rdy_q;
   assign drain  = main_vld & pop_ready;

   always_comb begin
      main_vld_n = main_vld;
      skid_vld_n = skid_vld;
      main_n     = main_q;
      skid_n     = skid_q;
      // ready is low whenever skid holds a beat, so accept and skid_vld never coincide
      if (skid_vld) begin
         if (drain) begin
            main_n     = skid_q;
            skid_vld_n = 1'b0;
         end
      end else if (accept) begin
         if (!main_vld || drain) begin
            main_n     = push_data;
            main_vld_n = 1'b1;
         end else begin
            skid_n     = push_data;
            skid_vld_n = 1'b1;
         end
      end else if (drain) begin
         main_vld_n = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
         rdy_q    <= 1'b0;
         main_q   <= '0;
         skid_q   <= '0;
      end else begin
         main_vld <= main_vld_n;
         skid_vld <= skid_vld_n;
         rdy_q    <= ~skid_vld_n;
         main_q   <= main_n;
         skid_q   <= skid_n;
      end
   end

   assign push_ready = rdy_q;
   assign pop_valid  = main_vld;
   assign pop_data   = main_q;

endmodule

// File: rtl/g_logic_pipe.sv
// Pipelined bitwise logic unit: op eval at accept, result held in a skid buffer.
// G_LOGIC_PIPE_FLAGS_EN stores zero/all-ones flags alongside each result.
module g_logic_pipe
   import g_logic_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             In_valid,
   output logic             In_ready,
   input  logic [OP_W-1:0]  Op,
   input  logic [WIDTH-1:0] In1,
   input  logic [WIDTH-1:0] In2,
   output logic             Out_valid,
   input  logic             Out_ready,
   output logic [WIDTH-1:0] Out,
   output logic             Out_zero,
   output logic             Out_ones
);

   logic [WIDTH-1:0] res;

   always_comb begin
      res = '0;
      for (int i = 0; i < WIDTH; i++)
         res[i] = g_logic_eval(g_op_e'(Op), In1[i], In2[i]);
   end

`ifdef G_LOGIC_PIPE_FLAGS_EN
   localparam int PW = WIDTH + 2;
   logic [PW-1:0] pay_in, pay_out;

   assign pay_in   = {~|res, &res, res};
   assign Out      = pay_out[WIDTH-1:0];
   assign Out_ones = pay_out[WIDTH];
   assign Out_zero = pay_out[WIDTH+1];
`else
   localparam int PW = WIDTH;
   logic [PW-1:0] pay_in, pay_out;

   assign pay_in   = res;
   assign Out      = pay_out;
   assign Out_ones = 1'b0;
   assign Out_zero = 1'b0;
`endif

   g_skid_reg #(.W(PW)) u_skid (
      .clk        (Clk),
      .rst_n      (Rst_n),
      .push_valid (In_valid),
      .push_ready (In_ready),
      .push_data  (pay_in),
      .pop_valid  (Out_valid),
      .pop_ready  (Out_ready),
      .pop_data   (pay_out)
   );

endmodule
